// File: rtl/logic_pipe_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
package logic_pipe_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  localparam int COUNT_W  = 16;
  // Widest operand the shared helper handles; callers zero-extend and truncate.
  localparam int OP_MAX_W = 64;

  function automatic logic [OP_MAX_W-1:0] bitwise_op(
    input op_t                 op,
    input logic [OP_MAX_W-1:0] a,
    input logic [OP_MAX_W-1:0] b
  );
    logic [OP_MAX_W-1:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: a valid flag plus its data word, with load and clear.
module pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q;
  logic [WIDTH-1:0] dat_q;

  // Bubbles only move the valid flag; data keeps its last value.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      vld_q <= vld_i;
      if (vld_i) dat_q <= dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready on both sides and a result counter.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic [COUNT_W-1:0] done_count
);

  logic [OP_MAX_W-1:0] res_ext;
  logic [WIDTH-1:0]    res_c;

  logic [STAGES-1:0]   vld_q;
  logic [STAGES-1:0]   load;
  logic [STAGES-1:0]   advance;
  logic [WIDTH-1:0]    dat_q [STAGES];

  logic [COUNT_W-1:0]  done_q, done_d;
  logic                out_hs;

  assign res_ext = bitwise_op(op_t'(op), OP_MAX_W'(a), OP_MAX_W'(b));
  assign res_c   = res_ext[WIDTH-1:0];

  // Ready ripples upstream from the consumer; an empty slot always loads.
  always_comb begin
    advance = '0;
    load    = '0;
    advance[STAGES-1] = vld_q[STAGES-1] && out_ready && !reset;
    load[STAGES-1]    = !vld_q[STAGES-1] || advance[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      advance[i] = vld_q[i] && load[i+1];
      load[i]    = !vld_q[i] || advance[i];
    end
  end

  assign in_ready = !reset && load[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;
    if (i == 0) begin : g_head
      assign up_vld = in_valid && in_ready;
      assign up_dat = res_c;
    end else begin : g_body
      assign up_vld = vld_q[i-1];
      assign up_dat = dat_q[i-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk),
      .clear_i (reset),
      .load_i  (load[i]),
      .vld_i   (up_vld),
      .dat_i   (up_dat),
      .vld_o   (vld_q[i]),
      .dat_o   (dat_q[i])
    );
  end

  // Outputs read as idle while reset is held, even before the registers clear.
  assign out_valid = vld_q[STAGES-1] && !reset;
  assign y         = reset ? '0 : dat_q[STAGES-1];
  assign busy      = (|vld_q) && !reset;

  assign out_hs = advance[STAGES-1];
  assign done_d = out_hs ? done_q + COUNT_W'(1) : done_q;

  always_ff @(posedge clk) begin
    if (reset) done_q <= '0;
    else       done_q <= done_d;
  end

  assign done_count = done_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: default, 3-stage and 16-bit instances.
module tb_logic_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=4, STAGES=2
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [2:0]  op0;
  logic [3:0]  a0, b0, y0;
  logic [15:0] done0;
  // Instance 1: WIDTH=4, STAGES=3
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [2:0]  op1;
  logic [3:0]  a1, b1, y1;
  logic [15:0] done1;
  // Instance 2: WIDTH=16, STAGES=2
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [2:0]  op2;
  logic [15:0] a2, b2, y2;
  logic [15:0] done2;

  logic_pipe #(.WIDTH(4), .STAGES(2)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .op(op0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0), .y(y0),
    .busy(busy0), .done_count(done0));

  logic_pipe #(.WIDTH(4), .STAGES(3)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .y(y1),
    .busy(busy1), .done_count(done1));

  logic_pipe #(.WIDTH(16), .STAGES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .y(y2),
    .busy(busy2), .done_count(done2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] y;
    int         stamp;
    bit         lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   lat_mode = 1'b0;
  int   acc0 = 0;

  task automatic send0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ey, input bit push);
    int t;
    in_valid0 = 1'b1; op0 = op; a0 = a; b0 = b;
    t = 0;
    @(negedge clk);
    while (!in_ready0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready0) begin
      checks++; errors++;
      $display("FAIL send0_timeout: in_ready got 0 expected 1");
    end else begin
      if (push) q.push_back('{ey, cyc, lat_mode});
      acc0++;
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_drain0();
    int t;
    t = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the expected result on every output handshake of instance 0.
  bit         stall_prev = 1'b0;
  logic [3:0] y_prev;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid0, 1);
        chk("hold_y", y0, y_prev);
      end
      if (out_valid0 && out_ready0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %0h expected no output", y0);
        end else begin
          e = q.pop_front();
          chk("y", y0, e.y);
          if (e.lat) chk("latency", cyc - e.stamp, 2);
        end
      end
      stall_prev = out_valid0 && !out_ready0;
      y_prev = y0;
    end
  end

  logic [3:0] sweep_exp [8];
  int  n_acc, n_out;
  bit  fin, seen;

  initial begin
    sweep_exp = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
    reset = 1'b1;
    in_valid0 = 0; op0 = 0; a0 = 0; b0 = 0; out_ready0 = 0;
    in_valid1 = 0; op1 = 0; a1 = 0; b1 = 0; out_ready1 = 0;
    in_valid2 = 0; op2 = 0; a2 = 0; b2 = 0; out_ready2 = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_y", y0, 0);
    chk("rst_busy", busy0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready0, 1);
    chk("idle_out_valid", out_valid0, 0);
    chk("idle_y", y0, 0);
    chk("idle_done", done0, 0);
    chk("idle_busy", busy0, 0);
    @(posedge clk); #1;

    // Op sweep, back-to-back, with latency check
    out_ready0 = 1'b1;
    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) send0(3'(i), 4'b1100, 4'b1010, sweep_exp[i], 1'b1);
    lat_mode = 1'b0;
    wait_drain0();
    chk("sweep_done", done0, 8);

    // Backpressure with NOT of 0..5
    out_ready0 = 1'b0;
    acc0 = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send0(3'd0, 4'(i), 4'd0, ~4'(i), 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", acc0, 2);
        chk("bp_in_ready", in_ready0, 0);
        chk("bp_out_valid", out_valid0, 1);
        chk("bp_y_hold", y0, 4'hF);
        @(posedge clk); #1;
        out_ready0 = 1'b1;
      end
    join
    wait_drain0();
    chk("bp_done", done0, 14);

    // Reset with two items in flight
    out_ready0 = 1'b0;
    send0(3'd1, 4'hF, 4'h3, 4'h3, 1'b0);
    send0(3'd2, 4'h1, 4'h2, 4'h3, 1'b0);
    @(negedge clk);
    chk("mid_busy_before", busy0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready0, 0);
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_y", y0, 0);
    chk("mid_rst_busy", busy0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", out_valid0, 0);
    chk("mid_busy", busy0, 0);
    chk("mid_done", done0, 0);
    chk("mid_in_ready", in_ready0, 1);
    repeat (4) @(negedge clk);
    chk("mid_no_stale", out_valid0, 0);
    chk("mid_done_after", done0, 0);
    @(posedge clk); #1;

    // Bubble collapse on the 3-stage instance
    in_valid1 = 1'b1; op1 = 3'd0; a1 = 4'd0;
    @(negedge clk);
    chk("bub_ready_a", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b1; a1 = 4'd1;
    @(negedge clk);
    chk("bub_ready_b", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bub_stage_vld", u1.vld_q, 3'b110);
    chk("bub_out_valid", out_valid1, 1);
    chk("bub_y", y1, 4'hF);
    chk("bub_in_ready", in_ready1, 1);
    chk("bub_busy", busy1, 1);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bub_y2", y1, 4'hE);
    chk("bub_out_valid2", out_valid1, 1);
    chk("bub_done1", done1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bub_empty", out_valid1, 0);
    chk("bub_done2", done1, 2);
    @(posedge clk); #1;

    // Counter wrap on the 16-bit instance
    in_valid2 = 1'b1; op2 = 3'd3; a2 = 16'hFFFF; b2 = 16'h00FF; out_ready2 = 1'b1;
    n_acc = 0; n_out = 0; fin = 1'b0; seen = 1'b0;
    for (int i = 0; i < 70000 && !fin; i++) begin
      @(negedge clk);
      if (out_valid2) begin
        n_out++;
        if (n_out >= 65535) chk("wrap_y", y2, 16'hFF00);
      end
      if (in_valid2 && in_ready2) n_acc++;
      @(posedge clk); #1;
      if (n_acc == 65536) in_valid2 = 1'b0;
      if (n_out == 65535 && !seen) begin
        seen = 1'b1;
        chk("count_ffff", done2, 16'hFFFF);
      end
      if (n_out == 65536) begin
        chk("count_wrap", done2, 16'h0000);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL wrap_timeout: got %0d handshakes expected 65536", n_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
